// File: rtl/ni_flit_sender.sv
// Credit-based flit transmitter: serializes header, size and payload flits
// toward a router local port, holding each flit stable until credit arrives.
module ni_flit_sender #(
   parameter int FLIT_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [FLIT_WIDTH/2-1:0] cmd_target,
   input  logic [FLIT_WIDTH-1:0]   cmd_size,
   input  logic                    pl_valid,
   output logic                    pl_ready,
   input  logic [FLIT_WIDTH-1:0]   pl_data,
   output logic                    clock_tx,
   output logic                    tx,
   output logic [FLIT_WIDTH-1:0]   data_out,
   input  logic                    credit_i,
   output logic                    pkt_done
);

   typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

   state_t                  state_q, state_d;
   logic                    tx_q, tx_d;
   logic [FLIT_WIDTH-1:0]   data_q, data_d;
   logic [FLIT_WIDTH-1:0]   remaining_q, remaining_d;
   logic                    pkt_done_q, pkt_done_d;
   logic                    xfer;
   logic [FLIT_WIDTH-1:0]   remaining_dec;

   assign clock_tx      = clock;
   assign tx            = tx_q;
   assign data_out      = data_q;
   assign pkt_done      = pkt_done_q;
   assign xfer          = tx_q && credit_i;
   assign remaining_dec = remaining_q - {{(FLIT_WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      data_d      = data_q;
      remaining_d = remaining_q;
      pkt_done_d  = 1'b0;
      cmd_ready   = 1'b0;
      pl_ready    = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready = !reset;
            if (cmd_valid && cmd_ready) begin
               data_d                   = '0;
               data_d[FLIT_WIDTH/2-1:0] = cmd_target;
               tx_d                     = 1'b1;
               remaining_d              = cmd_size;
               state_d                  = HEADER;
            end
         end

         HEADER: begin
            if (credit_i) begin
               data_d  = remaining_q;
               state_d = SIZE;
            end
         end

         SIZE: begin
            if (credit_i) begin
               if (remaining_q == '0) begin
                  tx_d       = 1'b0;
                  pkt_done_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  // First payload flit may ride the size-flit transfer edge.
                  pl_ready = !reset;
                  state_d  = PAYLOAD;
                  if (pl_valid) begin
                     data_d      = pl_data;
                     remaining_d = remaining_dec;
                  end else begin
                     tx_d = 1'b0;
                  end
               end
            end
         end

         PAYLOAD: begin
            pl_ready = !reset && (remaining_q != '0) && (!tx_q || credit_i);
            if (pl_valid && pl_ready) begin
               data_d      = pl_data;
               tx_d        = 1'b1;
               remaining_d = remaining_dec;
            end else if (xfer) begin
               tx_d = 1'b0;
               if (remaining_q == '0) begin
                  pkt_done_d = 1'b1;
                  state_d    = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         tx_q        <= 1'b0;
         data_q      <= '0;
         remaining_q <= '0;
         pkt_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         data_q      <= data_d;
         remaining_q <= remaining_d;
         pkt_done_q  <= pkt_done_d;
      end
   end

endmodule

// File: doc/ni_flit_sender.md
# ni_flit_sender

Credit-based packet transmitter for the network-interface side of a router local port. It takes a packet command (target address, payload length) plus a payload flit stream from the local processing element. It serializes them as header flit, size flit, then payload flits onto the router's `rx`/`data_in`/`credit_o` input port. Flits are held stable while the router withholds credit.

## Interface
- `FLIT_WIDTH`, default 32: flit width in bits (`TAM_FLIT`); the target address is `FLIT_WIDTH/2` bits (metade-flit).
- `clock`  in  1: single clock for the whole block.
- `reset`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: packet command present.
- `cmd_ready`  out  1: command accepted on a cycle where `cmd_valid && cmd_ready`.
- `cmd_target`  in  FLIT_WIDTH/2: destination router address (XY).
- `cmd_size`  in  FLIT_WIDTH: number of payload flits, 0 allowed.
- `pl_valid`  in  1: payload flit present.
- `pl_ready`  out  1: payload flit consumed on a cycle where `pl_valid && pl_ready`.
- `pl_data`  in  FLIT_WIDTH: payload flit.
- `clock_tx`  out  1: equals `clock` (combinational pass-through).
- `tx`  out  1: flit valid toward router.
- `data_out`  out  FLIT_WIDTH: flit toward router.
- `credit_i`  in  1: router has buffer space; a flit transfers on a rising edge where `tx && credit_i`.
- `pkt_done`  out  1: one-cycle pulse on the cycle after the last flit of a packet transfers.

## Operation
- FSM states: IDLE, HEADER, SIZE, PAYLOAD.
- **IDLE**
  - `cmd_ready = !reset`; `tx = 0`.
  - On cmd handshake: `data_out <= {zeros, cmd_target}`, `tx <= 1`, latch `cmd_size` into `remaining`, go to HEADER.
- **HEADER**
  - `tx = 1`, header held.
  - On `credit_i`: `data_out <= remaining` (size flit), go to SIZE.
- **SIZE**
  - `tx = 1`, size flit held.
  - On `credit_i` with `remaining == 0`: `tx <= 0`, pulse `pkt_done`, go to IDLE.
  - On `credit_i` with `remaining != 0`: go to PAYLOAD.
    - If `pl_valid`, load `pl_data` into `data_out` in the same edge (pl handshake), `tx` stays 1, decrement `remaining`.
    - Otherwise `tx <= 0`.
- **PAYLOAD**
  - Output register is a single-entry stage. `pl_ready = (state==PAYLOAD) && remaining != 0 && (!tx || credit_i)`.
  - On pl handshake: `data_out <= pl_data`, `tx <= 1`, `remaining <= remaining - 1`.
  - On transfer without pl handshake: `tx <= 0`.
  - Packet ends when the transfer occurs with `remaining == 0`: `tx <= 0`, pulse `pkt_done`, go to IDLE.
- **Stability rule:** while `tx && !credit_i`, `data_out` and `tx` must not change.
- `remaining` is an unsigned FLIT_WIDTH counter. It never decrements below 0, since `pl_ready` is low when `remaining == 0`.
- `cmd_ready` is 0 outside IDLE. A new command is never accepted mid-packet.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, `tx = 0`, `data_out = 0`, `remaining = 0`, `pkt_done = 0`.
  - `cmd_ready = 0` and `pl_ready = 0` while `reset` is high.
- Cmd handshake at edge N puts the header on `data_out` with `tx = 1` from edge N onward.
- With `credit_i` held at 1, flits occupy consecutive cycles with no bubbles: header, size, payload 0 … payload S-1. That is S+2 cycles of `tx = 1`.
  - `pkt_done` is high in cycle S+3 after acceptance.
  - The next command can be accepted in that same cycle (IDLE). There is a minimum one-cycle gap with `tx = 0` between packets.
- Payload latency: `pl_data` accepted at edge N appears on `data_out` at edge N.
- Reset mid-packet: the packet is aborted, `tx` drops immediately, and no partial state is retained.
- `credit_i` is ignored when `tx = 0`.

## Test plan
- **Reset state:** reset mid-PAYLOAD with `tx = 1`, `credit_i = 1` → `tx`, `data_out`, `pkt_done` become 0 asynchronously; after release `cmd_ready = 1`, and a fresh packet is sent correctly.
- **Streaming packet:** target 0x0102, size 3, payload A1/A2/A3 always valid, `credit_i = 1` → `data_out` = 0x00000102, 0x00000003, A1, A2, A3 on 5 consecutive cycles; `pkt_done` pulses once.
- **Zero-size packet:** size 0 → exactly 2 flits (header, 0x00000000); `pl_ready` never asserted; `pkt_done` after the size flit.
- **Credit stall:** `credit_i` low for 4 cycles during the header and during payload 1 → `data_out`/`tx` constant through each stall; no flit lost or duplicated; order preserved.
- **Payload starvation:** `pl_valid` low for 3 cycles after the size flit → `tx = 0` during the gap; resumes with the correct flit and count.
- **Back-to-back:** `cmd_valid` held high for two packets → second command accepted only in IDLE, after `pkt_done`; one-cycle gap with `tx = 0` between packets.
